// File: rtl/clock_pkg.sv
// clock_pkg: shared seven-segment patterns, BCD field type and time limits
package clock_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;
  function automatic logic bcd_at(bcd2_t v, int max);
    return v == bcd2_t'({4'(max / 10), 4'(max % 10)});
  endfunction
  // increment a two-digit BCD value, wrapping to 00 after max
  function automatic bcd2_t bcd_inc(bcd2_t v, int max);
    return bcd_at(v, max) ? '0 :
           v.ones == 4'd9 ? bcd2_t'({v.tens + 4'd1, 4'd0}) :
           bcd2_t'({v.tens, v.ones + 4'd1});
  endfunction
endpackage

// File: rtl/seg7_digit_enc.sv
// seg7_digit_enc: BCD digit to active-high gfedcba seven-segment pattern
//   bcd [3:0] in  : BCD digit 0..9
//   seg [6:0] out : segment pattern, blank for non-BCD codes
module seg7_digit_enc
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb
    seg = bcd == 4'd0 ? SEG_0 :
          bcd == 4'd1 ? SEG_1 :
          bcd == 4'd2 ? SEG_2 :
          bcd == 4'd3 ? SEG_3 :
          bcd == 4'd4 ? SEG_4 :
          bcd == 4'd5 ? SEG_5 :
          bcd == 4'd6 ? SEG_6 :
          bcd == 4'd7 ? SEG_7 :
          bcd == 4'd8 ? SEG_8 :
          bcd == 4'd9 ? SEG_9 : 7'h00;
endmodule

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day counter with seven-segment outputs
//   TICK_DIV       : clock cycles per second (>= 2)
//   clk, rst_n     : clock, asynchronous active-low reset
//   setting_enable : 1 freezes time and enables manual adjustment
//   set_hr_or_min  : 1 adjusts hours, 0 adjusts minutes
//   inc_short      : increment button, rising edge acts
//   hour, minute   : {tens_seg, ones_seg} seven-segment patterns
//   tick_out       : one-cycle pulse per counted second
//   second         : seconds display, present only with SECOND_OUT_EN defined
module time_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        setting_enable,
  input  logic        set_hr_or_min,
  input  logic        inc_short,
  output logic [13:0] hour,
  output logic [13:0] minute,
  output logic        tick_out
`ifdef SECOND_OUT_EN
  ,
  output logic [13:0] second
`endif
);
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0] div_cnt;
  bcd2_t sec, min, hr;
  logic inc_prev, wrap, inc_ev;
  assign wrap   = div_cnt == DW'(TICK_DIV - 1);
  assign inc_ev = inc_short & ~inc_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt  <= '0;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      inc_prev <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      inc_prev <= inc_short;
      if (setting_enable) begin
        // seconds stay cleared while frozen, which covers the entry clear
        div_cnt  <= '0;
        tick_out <= 1'b0;
        sec      <= '0;
        if (inc_ev && set_hr_or_min) hr <= bcd_inc(hr, HR_MAX);
        if (inc_ev && !set_hr_or_min) min <= bcd_inc(min, MIN_MAX);
      end else begin
        div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
        tick_out <= wrap;
        if (wrap) begin
          sec <= bcd_inc(sec, SEC_MAX);
          if (bcd_at(sec, SEC_MAX)) min <= bcd_inc(min, MIN_MAX);
          if (bcd_at(sec, SEC_MAX) && bcd_at(min, MIN_MAX)) hr <= bcd_inc(hr, HR_MAX);
        end
      end
    end
  seg7_digit_enc u_hr_t  (.bcd(hr.tens),  .seg(hour[13:7]));
  seg7_digit_enc u_hr_o  (.bcd(hr.ones),  .seg(hour[6:0]));
  seg7_digit_enc u_min_t (.bcd(min.tens), .seg(minute[13:7]));
  seg7_digit_enc u_min_o (.bcd(min.ones), .seg(minute[6:0]));
`ifdef SECOND_OUT_EN
  seg7_digit_enc u_sec_t (.bcd(sec.tens), .seg(second[13:7]));
  seg7_digit_enc u_sec_o (.bcd(sec.ones), .seg(second[6:0]));
`endif
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: randomized self-checking bench against a seconds-of-day model
module tb_time_counter;
  localparam int TD = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic setting_enable = 1'b0;
  logic set_hr_or_min = 1'b0;
  logic inc_short = 1'b0;
  logic [13:0] hour, minute;
  logic tick_out;
  int errors = 0;
  int checks = 0;
  int t = 0;
  int mcnt = 0;
  int mprev = 0;
  int mtick = 0;
  time_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .setting_enable(setting_enable),
    .set_hr_or_min(set_hr_or_min), .inc_short(inc_short),
    .hour(hour), .minute(minute), .tick_out(tick_out)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] pat(int v);
    return {SEG_TAB[v / 10], SEG_TAB[v % 10]};
  endfunction
  function automatic int mh();
    return t / 3600;
  endfunction
  function automatic int mm();
    return (t / 60) % 60;
  endfunction
  task automatic model_reset();
    t = 0;
    mcnt = 0;
    mprev = 0;
    mtick = 0;
  endtask
  task automatic step(input logic se, input logic sel, input logic inc);
    setting_enable = se;
    set_hr_or_min = sel;
    inc_short = inc;
    @(posedge clk);
    mtick = 0;
    if (!se) begin
      mcnt++;
      if (mcnt == TD) begin
        mcnt = 0;
        mtick = 1;
        t = (t + 1) % 86400;
      end
    end else begin
      mcnt = 0;
      t = t - t % 60;
      if (inc && mprev == 0)
        t = sel ? ((mh() + 1) % 24) * 3600 + t % 3600
                : mh() * 3600 + ((mm() + 1) % 60) * 60;
    end
    mprev = inc;
    @(negedge clk);
  endtask
  task automatic press(input logic sel);
    step(1'b1, sel, 1'b1);
    step(1'b1, sel, 1'b0);
  endtask
  task automatic test_reset();
    int first;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (hour !== 14'h1FBF) begin errors++; $display("FAIL reset_hour got=%h want=1fbf", hour); end
    checks++; if (minute !== 14'h1FBF) begin errors++; $display("FAIL reset_minute got=%h want=1fbf", minute); end
    checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick_out); end
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_out === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++; if (first != TD) begin errors++; $display("FAIL first_tick got=%0d want=%0d", first, TD); end
  endtask
  task automatic test_set_hours();
    step(1'b1, 1'b1, 1'b0);
    press(1'b1);
    checks++; if (hour !== 14'h1F86) begin errors++; $display("FAIL set_hour got=%h want=1f86", hour); end
    checks++; if (minute !== pat(mm())) begin errors++; $display("FAIL set_hour_min got=%h want=%h", minute, pat(mm())); end
  endtask
  task automatic test_hour_wrap();
    logic [13:0] m0;
    while (mh() != 0) press(1'b1);
    m0 = pat(mm());
    repeat (23) press(1'b1);
    checks++; if (hour !== pat(23)) begin errors++; $display("FAIL hour_23 got=%h want=%h", hour, pat(23)); end
    press(1'b1);
    checks++; if (hour !== 14'h1FBF) begin errors++; $display("FAIL hour_wrap got=%h want=1fbf", hour); end
    checks++; if (minute !== m0) begin errors++; $display("FAIL hour_wrap_min got=%h want=%h", minute, m0); end
  endtask
  task automatic test_min_wrap();
    logic [13:0] h0;
    h0 = pat(mh());
    while (mm() != 59) press(1'b0);
    checks++; if (minute !== 14'h36EF) begin errors++; $display("FAIL min_59 got=%h want=36ef", minute); end
    press(1'b0);
    checks++; if (minute !== 14'h1FBF) begin errors++; $display("FAIL min_wrap got=%h want=1fbf", minute); end
    checks++; if (hour !== h0) begin errors++; $display("FAIL min_wrap_hour got=%h want=%h", hour, h0); end
  endtask
  task automatic test_rollover();
    int ticks;
    for (int i = 0; i < 24 && mh() != 23; i++) press(1'b1);
    for (int i = 0; i < 60 && mm() != 59; i++) press(1'b0);
    checks++; if (hour !== pat(23) || minute !== pat(59)) begin errors++; $display("FAIL preload got=%h:%h want=%h:%h", hour, minute, pat(23), pat(59)); end
    ticks = 0;
    for (int i = 0; i < 60 * TD; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_out === 1'b1) ticks++;
      checks++; if (tick_out !== 1'(mtick) || hour !== pat(mh()) || minute !== pat(mm())) begin
        errors++; $display("FAIL rollover_cyc%0d got=%h:%h t%b want=%h:%h t%0d", i, hour, minute, tick_out, pat(mh()), pat(mm()), mtick);
      end
    end
    checks++; if (hour !== 14'h1FBF || minute !== 14'h1FBF) begin errors++; $display("FAIL rollover_end got=%h:%h want=1fbf:1fbf", hour, minute); end
    checks++; if (ticks != 60) begin errors++; $display("FAIL rollover_ticks got=%0d want=60", ticks); end
  endtask
  task automatic test_held_button();
    int h0;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    h0 = mh();
    repeat (3) step(1'b1, 1'b1, 1'b1);
    checks++; if (hour !== pat(h0)) begin errors++; $display("FAIL held_no_inc got=%h want=%h", hour, pat(h0)); end
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    checks++; if (hour !== pat((h0 + 1) % 24)) begin errors++; $display("FAIL held_one_inc got=%h want=%h", hour, pat((h0 + 1) % 24)); end
    step(1'b1, 1'b1, 1'b0);
    press(1'b1);
    checks++; if (hour !== pat((h0 + 2) % 24)) begin errors++; $display("FAIL held_second_press got=%h want=%h", hour, pat((h0 + 2) % 24)); end
  endtask
  task automatic test_random();
    logic se, sel, inc;
    se = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) se = ~se;
      sel = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 2) == 0);
      step(se, sel, inc);
      checks++; if (tick_out !== 1'(mtick) || hour !== pat(mh()) || minute !== pat(mm())) begin
        errors++; $display("FAIL random_cyc%0d got=%h:%h t%b want=%h:%h t%0d", i, hour, minute, tick_out, pat(mh()), pat(mm()), mtick);
      end
    end
  endtask
  task automatic test_async_reset();
    int first;
    press(1'b0);
    press(1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (hour !== 14'h1FBF || minute !== 14'h1FBF || tick_out !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%h:%h t%b want=1fbf:1fbf t0", hour, minute, tick_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_out === 1'b1) begin
        first = n;
        break;
      end
    end
    checks++; if (first != TD) begin errors++; $display("FAIL async_first_tick got=%0d want=%0d", first, TD); end
  endtask
  initial begin
    test_reset();
    test_set_hours();
    test_hour_wrap();
    test_min_wrap();
    test_rollover();
    test_held_button();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
